// File: rtl/cipher_ctrl_pkg.sv
// Shared types and constants for the cipher round controller.
// State encoding is fixed so that existing debug tooling can decode it.
package cipher_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   localparam int ROUNDS_DEFAULT = 10;

endpackage

// File: rtl/cipher_round_ctrl_rnd_updn_cnt.sv
// Up/down round-index counter with parallel load, step enable and a
// terminal-count flag compared against a caller-supplied terminal value.
module rnd_updn_cnt #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic          step,
   input  logic          down,
   input  logic [CW-1:0] load_val,
   input  logic [CW-1:0] term_val,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         if (load) begin
            cnt <= load_val;
         end else if (step) begin
            cnt <= down ? cnt - CW'(1) : cnt + CW'(1);
         end
      end
   end

   assign tc = (cnt == term_val);

endmodule

// File: rtl/cipher_round_ctrl.sv
// Block-operation sequencer for the cipher datapath: LOAD, ROUNDS rounds of
// PHASE_CYC cycles each, then a one-cycle DONE; encrypt counts up, decrypt down.
module cipher_round_ctrl
   import cipher_ctrl_pkg::*;
#(
   parameter int ROUNDS    = ROUNDS_DEFAULT,
   parameter int CW        = 4,
   parameter int PHASE_CYC = 1,
   parameter int PW        = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          start,
   input  logic          mode,
   input  logic          abort,
   output logic          ready,
   output logic          busy,
   output logic          ld_state,
   output logic [CW-1:0] rnd_idx,
   output logic [PW-1:0] phase,
   output logic          rnd_adv,
   output logic          key_upd,
   output logic          mix_en,
   output logic          last_rnd,
   output logic          done
);

   if (ROUNDS < 2) begin : g_chk_rounds
      $error("cipher_round_ctrl: ROUNDS must be at least 2");
   end
   if ((1 << CW) <= ROUNDS) begin : g_chk_cw
      $error("cipher_round_ctrl: CW too narrow for ROUNDS");
   end
   if (PHASE_CYC < 1) begin : g_chk_phase
      $error("cipher_round_ctrl: PHASE_CYC must be at least 1");
   end
   if ((1 << PW) < PHASE_CYC) begin : g_chk_pw
      $error("cipher_round_ctrl: PW too narrow for PHASE_CYC");
   end

   localparam logic [CW-1:0] IDX_LAST = CW'(ROUNDS - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(PHASE_CYC - 1);

   state_t        state;
   state_t        state_d;
   logic [PW-1:0] phase_q;
   logic          mode_q;
   logic          in_round;
   logic          ph_wrap;
   logic          rnd_tc;
   logic          is_dec;
   logic          accept;

   assign in_round = (state == ST_ROUND);
   assign ph_wrap  = in_round && (phase_q == PH_LAST);
   assign is_dec   = (mode_q == MODE_DEC);
   assign accept   = (state == ST_IDLE) && start && !abort;

   // Final-round index is the counter's terminal value, so the step is
   // suppressed there and rnd_idx parks on it through DONE and IDLE.
   rnd_updn_cnt #(.CW(CW)) u_rnd_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (state == ST_LOAD),
      .step     (ph_wrap && !rnd_tc && !abort),
      .down     (is_dec),
      .load_val (is_dec ? IDX_LAST : '0),
      .term_val (is_dec ? '0 : IDX_LAST),
      .cnt      (rnd_idx),
      .tc       (rnd_tc)
   );

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state;
      case (state)
         ST_IDLE:  if (accept) state_d = ST_LOAD;
         ST_LOAD:  state_d = abort ? ST_IDLE : ST_ROUND;
         ST_ROUND: begin
            if (abort)                 state_d = ST_IDLE;
            else if (ph_wrap && rnd_tc) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         phase_q <= '0;
         mode_q  <= MODE_ENC;
      end else if (en) begin
         state <= state_d;
         if (accept) mode_q <= mode;
         if ((state == ST_LOAD) || ph_wrap) begin
            phase_q <= '0;
         end else if (in_round) begin
            phase_q <= phase_q + PW'(1);
         end
      end
   end

   assign ready    = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign ld_state = (state == ST_LOAD);
   assign phase    = phase_q;
   assign rnd_adv  = ph_wrap;
   assign key_upd  = ph_wrap && !rnd_tc;
   assign mix_en   = in_round && !rnd_tc;
   assign last_rnd = in_round && rnd_tc;
   assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Self-checking bench: two controllers (default and ROUNDS=4/PHASE_CYC=3)
// checked every cycle against a timeline model, plus directed scenarios.
module tb_cipher_round_ctrl;
   import cipher_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_i[2], en_i[2], start_i[2], mode_i[2], abort_i[2];

   logic       a_ready, a_busy, a_ld, a_adv, a_key, a_mix, a_last, a_done;
   logic [3:0] a_idx;
   logic [1:0] a_ph;
   logic       b_ready, b_busy, b_ld, b_adv, b_key, b_mix, b_last, b_done;
   logic [2:0] b_idx;
   logic [1:0] b_ph;

   cipher_round_ctrl u_dut_a (
      .clk(clk), .rst(rst_i[0]), .en(en_i[0]), .start(start_i[0]),
      .mode(mode_i[0]), .abort(abort_i[0]), .ready(a_ready), .busy(a_busy),
      .ld_state(a_ld), .rnd_idx(a_idx), .phase(a_ph), .rnd_adv(a_adv),
      .key_upd(a_key), .mix_en(a_mix), .last_rnd(a_last), .done(a_done)
   );

   cipher_round_ctrl #(.ROUNDS(4), .CW(3), .PHASE_CYC(3), .PW(2)) u_dut_b (
      .clk(clk), .rst(rst_i[1]), .en(en_i[1]), .start(start_i[1]),
      .mode(mode_i[1]), .abort(abort_i[1]), .ready(b_ready), .busy(b_busy),
      .ld_state(b_ld), .rnd_idx(b_idx), .phase(b_ph), .rnd_adv(b_adv),
      .key_upd(b_key), .mix_en(b_mix), .last_rnd(b_last), .done(b_done)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Timeline model: an operation is "t cycles since acceptance".
   int  rr[2] = '{10, 4};
   int  pp[2] = '{1, 3};
   bit  act[2], md[2], hval[2];
   int  tt[2], hidx[2], hph[2];
   int  adv_cnt[2], key_cnt[2];
   int  cyc = 0;
   int  acc_cyc[2];
   bit  armed = 0;

   function automatic logic [7:0] obs_flags(input int i);
      if (i == 0) return {a_ready, a_busy, a_ld, a_adv, a_key, a_mix, a_last, a_done};
      return {b_ready, b_busy, b_ld, b_adv, b_key, b_mix, b_last, b_done};
   endfunction

   function automatic int obs_idx(input int i);
      return (i == 0) ? int'(a_idx) : int'(b_idx);
   endfunction

   function automatic int obs_ph(input int i);
      return (i == 0) ? int'(a_ph) : int'(b_ph);
   endfunction

   function automatic bit obs_done(input int i);
      return (i == 0) ? a_done : b_done;
   endfunction

   function automatic bit in_rnd(input int i);
      return act[i] && tt[i] >= 2 && tt[i] <= 1 + rr[i] * pp[i];
   endfunction

   function automatic logic [7:0] exp_flags(input int i);
      int  rp  = rr[i] * pp[i];
      bit  rnd = in_rnd(i);
      int  k   = tt[i] - 2;
      bit  adv = rnd && (k % pp[i] == pp[i] - 1);
      bit  lst = rnd && (k / pp[i] == rr[i] - 1);
      return {!act[i], act[i], act[i] && tt[i] == 1, adv, adv && !lst,
              rnd && !lst, lst, act[i] && tt[i] == 2 + rp};
   endfunction

   task automatic model_step(input int i);
      int rp = rr[i] * pp[i];
      if (rst_i[i]) begin
         act[i] = 0; hval[i] = 1; hidx[i] = 0; hph[i] = 0; md[i] = 0;
      end else if (en_i[i]) begin
         if (!act[i]) begin
            if (start_i[i] && !abort_i[i]) begin
               act[i] = 1; tt[i] = 1; md[i] = mode_i[i]; hval[i] = 0;
            end
         end else if (abort_i[i] && tt[i] <= 1 + rp) begin
            act[i] = 0; hval[i] = 0;
         end else if (tt[i] == 2 + rp) begin
            act[i] = 0;
         end else begin
            tt[i]++;
            if (tt[i] == 2 + rp) begin
               hval[i] = 1; hph[i] = 0;
               hidx[i] = md[i] ? 0 : rr[i] - 1;
            end
         end
      end
   endtask

   task automatic compare(input int i);
      logic [7:0] f = obs_flags(i);
      int k = tt[i] - 2;
      check($sformatf("flags%0d", i), f, exp_flags(i));
      if (f[4]) adv_cnt[i]++;
      if (f[3]) key_cnt[i]++;
      if (in_rnd(i)) begin
         check($sformatf("idx%0d", i), obs_idx(i),
               md[i] ? rr[i] - 1 - k / pp[i] : k / pp[i]);
         check($sformatf("phase%0d", i), obs_ph(i), k % pp[i]);
      end else if (hval[i]) begin
         check($sformatf("idx_hold%0d", i), obs_idx(i), hidx[i]);
         check($sformatf("phase_hold%0d", i), obs_ph(i), hph[i]);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (armed) for (int i = 0; i < 2; i++) compare(i);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
      armed = 1;
      cyc++;
      #1;
   endtask

   task automatic start_op(input int i, input logic m);
      adv_cnt[i] = 0;
      key_cnt[i] = 0;
      start_i[i] = 1'b1;
      mode_i[i]  = m;
      tick();
      start_i[i] = 1'b0;
      acc_cyc[i] = cyc;
      check($sformatf("ld_pulse%0d", i), obs_flags(i), 8'b0110_0000);
   endtask

   // Returns the cycle offset (k+n) at which done was seen.
   task automatic wait_done(input int i, input int budget, output int lat);
      while (!obs_done(i) && (cyc - acc_cyc[i]) < budget) tick();
      lat = cyc - acc_cyc[i] + 1;
   endtask

   int lat;
   int n;

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_i[i] = 1; en_i[i] = 1; start_i[i] = 0; mode_i[i] = 0; abort_i[i] = 0;
      end
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_flags%0d", i), obs_flags(i), 8'b1000_0000);
         check($sformatf("rst_idx%0d", i), obs_idx(i), 0);
         check($sformatf("rst_phase%0d", i), obs_ph(i), 0);
         rst_i[i] = 0;
      end
      tick();

      // Encrypt on defaults, with start pulses and mode flips while busy.
      start_op(0, MODE_ENC);
      for (int j = 0; j < 3; j++) begin
         start_i[0] = 1'b1;
         mode_i[0]  = ~mode_i[0];
         tick();
      end
      start_i[0] = 1'b0;
      wait_done(0, 40, lat);
      check("enc_latency", lat, 12);
      tick();
      check("enc_ready_after", a_ready, 1);
      check("enc_adv_count", adv_cnt[0], 10);
      check("enc_key_count", key_cnt[0], 9);
      check("enc_final_idx", a_idx, 9);

      // Decrypt on the multi-cycle instance.
      start_op(1, MODE_DEC);
      wait_done(1, 40, lat);
      check("dec_latency", lat, 14);
      tick();
      check("dec_adv_count", adv_cnt[1], 4);
      check("dec_key_count", key_cnt[1], 3);
      check("dec_final_idx", b_idx, 0);

      // Abort in round 5, then a full operation.
      start_op(0, MODE_ENC);
      n = 0;
      while (a_idx != 4'd5 && n < 20) begin tick(); n++; end
      check("abort_reach_idx5", a_idx, 5);
      abort_i[0] = 1'b1;
      tick();
      abort_i[0] = 1'b0;
      check("abort_idle", obs_flags(0), 8'b1000_0000);
      repeat (3) tick();
      start_op(0, MODE_ENC);
      wait_done(0, 40, lat);
      check("post_abort_latency", lat, 12);
      tick();

      // Clock enable low for 3 cycles mid-round.
      start_op(0, MODE_ENC);
      repeat (4) tick();
      en_i[0] = 1'b0;
      repeat (3) begin
         tick();
         check("en_freeze_idx", a_idx, 3);
      end
      en_i[0] = 1'b1;
      wait_done(0, 40, lat);
      check("en_freeze_latency", lat, 15);
      tick();

      // start and abort together in IDLE.
      start_i[0] = 1'b1;
      abort_i[0] = 1'b1;
      tick();
      start_i[0] = 1'b0;
      abort_i[0] = 1'b0;
      check("start_abort_idle", obs_flags(0), 8'b1000_0000);
      tick();

      // Reset during DONE.
      start_op(0, MODE_DEC);
      wait_done(0, 40, lat);
      check("dec_default_latency", lat, 12);
      rst_i[0] = 1'b1;
      tick();
      rst_i[0] = 1'b0;
      check("rst_done_flags", obs_flags(0), 8'b1000_0000);
      check("rst_done_idx", a_idx, 0);
      tick();

      // start held high: back-to-back issue interval.
      start_i[1] = 1'b1;
      mode_i[1]  = MODE_ENC;
      tick();
      acc_cyc[1] = cyc;
      wait_done(1, 40, lat);
      check("b2b_latency", lat, 14);
      n = 0;
      while (!b_ld && n < 5) begin tick(); n++; end
      start_i[1] = 1'b0;
      check("b2b_interval", cyc - acc_cyc[1], 15);
      acc_cyc[1] = cyc;
      wait_done(1, 40, lat);
      check("b2b_second_latency", lat, 14);
      tick();

      // Randomized traffic on both instances.
      for (int j = 0; j < 2000; j++) begin
         for (int i = 0; i < 2; i++) begin
            rst_i[i]   = ($urandom_range(0, 199) == 0);
            en_i[i]    = ($urandom_range(0, 9) != 0);
            start_i[i] = ($urandom_range(0, 2) == 0);
            mode_i[i]  = 1'($urandom_range(0, 1));
            abort_i[i] = ($urandom_range(0, 29) == 0);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         rst_i[i] = 0; en_i[i] = 1; start_i[i] = 0; abort_i[i] = 0;
      end
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
